// File: rtl/deal_sequencer.sv
// deal_sequencer: baccarat round sequencer issuing card-load strobes, applying the
// third-card rules and keeping win/tie tallies.
module deal_sequencer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic       fast_clock,
  input  logic       resetb,
  input  logic       deal_req,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       busy,
  output logic       done,
  output logic       player_win,
  output logic       dealer_win,
  output logic [7:0] player_wins,
  output logic [7:0] dealer_wins,
  output logic [7:0] ties
);
  typedef enum logic [3:0] {IDLE, P1, D1, P2, D2, DEC_P, P3, DEC_D, D3, SETTLE, FINISH} state_t;
  localparam logic [3:0] LAST = 4'(STEP_CYCLES - 1);
  localparam logic [3:0] SHORT = 4'(STEP_CYCLES - 2);
  state_t state;
  logic [3:0] cnt;
  logic [3:0] v;
  logic prev, nat, pdrew;
  logic natural, pdraw, tableau, ddraw;
  assign natural = pscore >= 4'd8 || dscore >= 4'd8;
  assign pdraw = !natural && pscore <= 4'd5;
  assign v = pcard3 >= 4'd10 ? 4'd0 : pcard3;
  assign tableau = dscore <= 4'd2 || (dscore == 4'd3 && v != 4'd8) ||
                   (dscore == 4'd4 && v >= 4'd2 && v <= 4'd7) ||
                   (dscore == 4'd5 && v >= 4'd4 && v <= 4'd7) ||
                   (dscore == 4'd6 && v >= 4'd6 && v <= 4'd7);
  assign ddraw = pdrew ? tableau : dscore <= 4'd5;
  // Strobes are registered, so each decision is taken on the edge that enters its state.
  always_ff @(posedge fast_clock) begin
    if (!resetb) begin
      state <= IDLE;
      cnt <= '0;
      prev <= 1'b1;
      nat <= 1'b0;
      pdrew <= 1'b0;
      {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3} <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      player_win <= 1'b0;
      dealer_win <= 1'b0;
      player_wins <= '0;
      dealer_wins <= '0;
      ties <= '0;
    end else begin
      prev <= deal_req;
      {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3} <= '0;
      done <= 1'b0;
      case (state)
        IDLE: if (deal_req && !prev) begin
          state <= P1;
          load_pcard1 <= 1'b1;
          busy <= 1'b1;
          cnt <= LAST;
        end
        P1: if (cnt == 4'd0) begin
          state <= D1;
          load_dcard1 <= 1'b1;
          cnt <= LAST;
        end else cnt <= cnt - 4'd1;
        D1: if (cnt == 4'd0) begin
          state <= P2;
          load_pcard2 <= 1'b1;
          cnt <= LAST;
        end else cnt <= cnt - 4'd1;
        P2: if (cnt == 4'd0) begin
          state <= D2;
          load_dcard2 <= 1'b1;
          cnt <= LAST;
        end else cnt <= cnt - 4'd1;
        D2: if (cnt == 4'd0) begin
          state <= DEC_P;
          nat <= natural;
          pdrew <= pdraw;
          load_pcard3 <= pdraw;
        end else cnt <= cnt - 4'd1;
        DEC_P: begin
          state <= nat ? SETTLE : pdrew ? P3 : DEC_D;
          load_dcard3 <= !nat && !pdrew && ddraw;
          cnt <= SHORT;
        end
        P3: if (cnt == 4'd0) begin
          state <= DEC_D;
          load_dcard3 <= ddraw;
        end else cnt <= cnt - 4'd1;
        DEC_D: begin
          state <= load_dcard3 ? D3 : SETTLE;
          cnt <= SHORT;
        end
        D3: if (cnt == 4'd0) state <= SETTLE;
          else cnt <= cnt - 4'd1;
        SETTLE: begin
          state <= FINISH;
          busy <= 1'b0;
          done <= 1'b1;
          player_win <= pscore >= dscore;
          dealer_win <= pscore <= dscore;
          if (pscore > dscore && player_wins != 8'hFF) player_wins <= player_wins + 8'd1;
          if (pscore < dscore && dealer_wins != 8'hFF) dealer_wins <= dealer_wins + 8'd1;
          if (pscore == dscore && ties != 8'hFF) ties <= ties + 8'd1;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_deal_sequencer.sv
// tb_deal_sequencer: directed rounds checked every cycle against a round-schedule model
// derived from the baccarat rules, plus hand-computed timing and tally checks.
module tb_deal_sequencer;
  localparam int S = 4;
  typedef struct {int p2; int d2; int c3; int pf; int df;} vec_t;
  logic fast_clock = 1'b0;
  logic resetb = 1'b0;
  logic deal_req = 1'b0;
  logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;
  logic load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3;
  logic busy, done, player_win, dealer_win;
  logic [7:0] player_wins, dealer_wins, ties;
  vec_t vecs[9];
  vec_t cur_v;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  bit m_active = 1'b0, m_prev = 1'b1, m_edge, m_pw = 1'b0, m_dw = 1'b0;
  int m_k, m_p3, m_d3, m_fin, m_fp, m_fd;
  logic [7:0] m_pws = '0, m_dws = '0, m_ties = '0;
  int r_p3, r_d3, r_done, r_nstb, cnt_a;

  deal_sequencer #(.STEP_CYCLES(S)) dut (
    .fast_clock(fast_clock), .resetb(resetb), .deal_req(deal_req),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .busy(busy), .done(done), .player_win(player_win), .dealer_win(dealer_win),
    .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties)
  );

  always #5 fast_clock = ~fast_clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit dealer_draws(input int d, input int c3, input bit pd);
    int v;
    v = c3 >= 10 ? 0 : c3;
    if (!pd) return d <= 5;
    if (d <= 2) return 1'b1;
    if (d == 3) return v != 8;
    if (d == 4) return v >= 2 && v <= 7;
    if (d == 5) return v >= 4 && v <= 7;
    if (d == 6) return v >= 6 && v <= 7;
    return 1'b0;
  endfunction

  // Cycle offsets (from the accepted edge) of every event of one round.
  task automatic plan(input vec_t r);
    bit nat, pd, dd;
    int decp, decd;
    nat = r.p2 >= 8 || r.d2 >= 8;
    pd = !nat && r.p2 <= 5;
    dd = !nat && dealer_draws(r.d2, r.c3, pd);
    decp = 1 + 4 * S;
    decd = pd ? decp + S : decp + 1;
    m_p3 = pd ? decp : -1;
    m_d3 = dd ? decd : -1;
    m_fin = nat ? decp + 2 : dd ? decd + S + 1 : decd + 2;
    m_fp = pd ? r.pf : r.p2;
    m_fd = dd ? r.df : r.d2;
  endtask

  initial forever begin
    @(posedge fast_clock);
    if (!resetb) begin
      m_active = 1'b0; m_prev = 1'b1; m_pw = 1'b0; m_dw = 1'b0;
      m_pws = '0; m_dws = '0; m_ties = '0;
    end else begin
      m_edge = deal_req && !m_prev;
      m_prev = deal_req;
      if (m_active) begin
        m_k++;
        if (m_k > m_fin) m_active = 1'b0;
      end else if (m_edge) begin
        m_active = 1'b1;
        m_k = 1;
        plan(cur_v);
      end
      if (m_active && m_k == m_fin) begin
        m_pw = m_fp >= m_fd;
        m_dw = m_fp <= m_fd;
        if (m_fp > m_fd && m_pws != 8'hFF) m_pws++;
        if (m_fp < m_fd && m_dws != 8'hFF) m_dws++;
        if (m_fp == m_fd && m_ties != 8'hFF) m_ties++;
      end
    end
  end

  function automatic logic [33:0] model_out();
    logic [5:0] s;
    logic b, d;
    s = '0; b = 1'b0; d = 1'b0;
    if (m_active) begin
      s = {m_k == 1, m_k == 1 + S, m_k == 1 + 2 * S, m_k == 1 + 3 * S, m_k == m_p3, m_k == m_d3};
      b = m_k < m_fin;
      d = m_k == m_fin;
    end
    return {s, b, d, m_pw, m_dw, m_pws, m_dws, m_ties};
  endfunction

  function automatic logic [33:0] dut_out();
    return {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3,
            busy, done, player_win, dealer_win, player_wins, dealer_wins, ties};
  endfunction

  initial forever begin
    @(negedge fast_clock);
    if (chk_en) check("cycle_outputs", 64'(dut_out()), 64'(model_out()));
  end

  function automatic int nstrobes();
    return int'(load_pcard1) + int'(load_pcard2) + int'(load_pcard3) +
           int'(load_dcard1) + int'(load_dcard2) + int'(load_dcard3);
  endfunction

  // Also acts as the datapath: third cards change the scores when their strobes fire.
  task automatic run_round(input int idx, input bit toggle);
    @(negedge fast_clock);
    cur_v = vecs[idx];
    pscore = 4'(cur_v.p2); dscore = 4'(cur_v.d2); pcard3 = 4'(cur_v.c3);
    deal_req = 1'b1;
    r_p3 = -1; r_d3 = -1; r_done = -1; r_nstb = 0;
    for (int n = 1; n <= 80 && r_done < 0; n++) begin
      @(negedge fast_clock);
      deal_req = toggle && (n % 4 >= 2);
      r_nstb += nstrobes();
      if (load_pcard3) begin r_p3 = n; pscore = 4'(cur_v.pf); end
      if (load_dcard3) begin r_d3 = n; dscore = 4'(cur_v.df); end
      if (done) begin r_done = n; deal_req = 1'b0; end
    end
    if (r_done < 0) begin
      checks++; errors++;
      $display("FAIL round_timeout: got no done expected done for vector %0d", idx);
    end
  endtask

  initial begin
    vecs[0] = '{8, 3, 0, 8, 3};
    vecs[1] = '{4, 3, 9, 2, 7};
    vecs[2] = '{4, 4, 12, 6, 9};
    vecs[3] = '{3, 6, 6, 9, 8};
    vecs[4] = '{5, 5, 10, 5, 9};
    vecs[5] = '{7, 7, 0, 7, 7};
    vecs[6] = '{6, 5, 0, 6, 2};
    vecs[7] = '{2, 9, 0, 2, 9};
    vecs[8] = '{8, 8, 0, 8, 8};
    cur_v = vecs[0];
    repeat (2) @(negedge fast_clock);
    chk_en = 1'b1;
    check("reset_outputs", 64'(dut_out()), 64'd0);
    resetb = 1'b1;
    run_round(0, 1'b0);
    check("nat_done_at", r_done, 19);
    check("nat_strobes", r_nstb, 4);
    check("nat_lights", {player_win, dealer_win}, 2'b10);
    check("nat_player_wins", player_wins, 1);
    run_round(1, 1'b0);
    check("both_pcard3_at", r_p3, 17);
    check("both_dcard3_at", r_d3, 21);
    check("both_done_at", r_done, 26);
    check("both_lights", {player_win, dealer_win}, 2'b01);
    check("both_dealer_wins", dealer_wins, 1);
    run_round(2, 1'b0);
    check("face_no_dcard3", r_d3, -1);
    check("face_done_at", r_done, 23);
    run_round(3, 1'b0);
    check("d6_v6_dcard3_at", r_d3, 21);
    run_round(4, 1'b0);
    check("tie_lights", {player_win, dealer_win}, 2'b11);
    check("tie_count", ties, 1);
    run_round(5, 1'b0);
    check("stand_done_at", r_done, 20);
    run_round(6, 1'b0);
    check("stand_dcard3_at", r_d3, 18);
    check("stand_draw_done_at", r_done, 23);
    run_round(7, 1'b0);
    check("dealer_nat_wins", dealer_wins, 2);
    run_round(0, 1'b1);
    check("toggle_strobes", r_nstb, 4);
    check("toggle_done_at", r_done, 19);
    check("toggle_player_wins", player_wins, 5);
    @(negedge fast_clock);
    cur_v = vecs[1];
    pscore = 4'(cur_v.p2); dscore = 4'(cur_v.d2); pcard3 = 4'(cur_v.c3);
    deal_req = 1'b1;
    repeat (4) begin @(negedge fast_clock); deal_req = 1'b0; end
    resetb = 1'b0;
    @(negedge fast_clock);
    resetb = 1'b1;
    check("abort_outputs", 64'(dut_out()), 64'd0);
    cnt_a = 0;
    repeat (30) begin @(negedge fast_clock); cnt_a += nstrobes(); end
    check("abort_no_strobes", cnt_a, 0);
    deal_req = 1'b1;
    resetb = 1'b0;
    @(negedge fast_clock);
    resetb = 1'b1;
    cnt_a = 0;
    repeat (30) begin @(negedge fast_clock); cnt_a += int'(busy); end
    check("held_req_no_round", cnt_a, 0);
    deal_req = 1'b0;
    repeat (255) run_round(8, 1'b0);
    check("ties_255", ties, 255);
    run_round(8, 1'b0);
    check("ties_saturated", ties, 255);
    check("sat_lights", {player_win, dealer_win}, 2'b11);
    @(negedge fast_clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/deal_sequencer.md
DEAL_SEQUENCER -- requirements
Module: deal_sequencer

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 4, giving the cycle spacing between load strobes and the datapath settle time; legal range 2..15.
REQ-002 SHALL have port fast_clock  in  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port resetb  in  1  synchronous, active-low reset.
REQ-004 SHALL have port deal_req  in  1  request for one complete round; the rising edge is the trigger.
REQ-005 SHALL have port pscore  in  4  player hand score from the datapath, 0..9.
REQ-006 SHALL have port dscore  in  4  dealer hand score from the datapath, 0..9.
REQ-007 SHALL have port pcard3  in  4  player third-card rank from the datapath, 0..13 (0 = no card).
REQ-008 SHALL have ports load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3  out  1 each  one-cycle datapath load strobes.
REQ-009 SHALL have port busy  out  1  high while a round is in progress.
REQ-010 SHALL have port done  out  1  one-cycle pulse at round completion.
REQ-011 SHALL have ports player_win, dealer_win  out  1 each  result lights for the last completed round; both high means a tie.
REQ-012 SHALL have ports player_wins, dealer_wins, ties  out  8 each  round tallies.

Function
REQ-013 SHALL detect the deal_req rising edge as deal_req=1 in the current cycle and 0 in the previous sampled cycle.
REQ-014 SHALL accept a rising edge only in IDLE; edges while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-015 SHALL use the states IDLE, P1, D1, P2, D2, DEC_P, P3, DEC_D, D3, SETTLE, FINISH.
REQ-016 SHALL, on an accepted edge in cycle T, assert busy from T+1 and pulse load_pcard1 in T+1.
REQ-017 SHALL issue load_dcard1, load_pcard2 and load_dcard2 at T+1+STEP_CYCLES, T+1+2*STEP_CYCLES and T+1+3*STEP_CYCLES respectively.
REQ-018 SHALL assert at most one load strobe per cycle, each high for exactly one cycle.
REQ-019 SHALL evaluate scores in DEC_P, STEP_CYCLES cycles after load_dcard2.
REQ-020 SHALL go to SETTLE (natural) if pscore>=8 or dscore>=8.
REQ-021 SHALL otherwise, if pscore<=5, pulse load_pcard3 in the DEC_P cycle, then enter DEC_D STEP_CYCLES cycles later.
REQ-022 SHALL otherwise (pscore 6..7) enter DEC_D in the next cycle without drawing.
REQ-023 SHALL, in DEC_D when the player did not draw, draw for the dealer iff dscore<=5.
REQ-024 SHALL, in DEC_D when the player drew, use v = 0 if pcard3>=10, else v = pcard3.
REQ-025 SHALL, with v from REQ-024, draw for the dealer iff: dscore<=2; or dscore=3 and v!=8; or dscore=4 and v in 2..7; or dscore=5 and v in 4..7; or dscore=6 and v in 6..7. dscore=7 SHALL never draw.
REQ-026 SHALL pulse load_dcard3 in the DEC_D cycle when the dealer draws.
REQ-027 SHALL make SETTLE last STEP_CYCLES cycles after the last strobe, or 1 cycle after a natural or no-draw decision.
REQ-028 SHALL, in FINISH, compare pscore with dscore: greater sets player_win=1, dealer_win=0; less sets dealer_win=1, player_win=0; equal sets both to 1.
REQ-029 SHALL, in FINISH, increment the matching tally, saturating at 255 (255 stays 255).
REQ-030 SHALL, in FINISH, pulse done=1 for one cycle and drive busy=0, then return to IDLE.
REQ-031 SHALL hold the win lights until the next FINISH; they are not cleared at the start of a new round.
REQ-032 SHALL accept a new edge in the cycle after FINISH.

Reset
REQ-033 SHALL, when resetb=0 at a rising edge, force state to IDLE in the next cycle.
REQ-034 SHALL, on reset, clear all strobes, busy, done, player_win and dealer_win to 0, and all tallies to 0.
REQ-035 SHALL set the previous deal_req sample to 1 on reset, so a request held high through reset does not start a round.
REQ-036 SHALL, on reset mid-round, abort without further strobes and leave tallies at 0.

Verification
REQ-037 Natural: STEP_CYCLES=4; edge at T; after 2 cards each, pscore=8, dscore=3 -> strobes at T+1, T+5, T+9, T+13 only; player_win=1, dealer_win=0; player_wins=1.
REQ-038 Both draw: pscore=4, dscore=3, pcard3=9 -> load_pcard3 at T+17, load_dcard3 at T+21; with final pscore=2, dscore=7 -> dealer_win=1, dealer_wins=1.
REQ-039 Face-card value: player draws, pcard3=12 (v=0), dscore=4 -> no load_dcard3; pcard3=6, dscore=6 -> load_dcard3 pulses.
REQ-040 Tie and saturation: final pscore=dscore=5 -> both lights high; ties preloaded to 255 via 255 tie rounds stays 255 after a further tie.
REQ-041 Busy and reset: deal_req toggled during a round -> no extra strobes; resetb=0 mid-round -> busy=0 and no strobes next cycle; deal_req held high through reset release -> no round starts.
